txn_return_reorder: RTL
=======================

# txn_return_reorder

Parametrised in-order completion buffer for the TXN controller front end. It accepts out-of-order read and write completions tagged with the request index issued at scheduling time. It stores each completion in a per-type slot array and releases it strictly in tag order, over ready/valid output channels with backpressure. It sits between the memory back end's response path and the front end's requester interface.

## Interface
- `DATA_W`, default 32: read data width in bits.
- `TAG_W`, default 6: tag width; slot depth per type = 2^TAG_W.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high. Sampled on `posedge clk` only; asserted for 1+ cycles clears all state.
- `in_valid` in 1: one completion presented this cycle.
- `in_type` in 1: `request_t` (read/write) from `types_def`.
- `in_tag` in TAG_W: completion tag.
- `in_data` in DATA_W: read data; ignored for writes.
- `rd_valid` out 1: in-order read completion available.
- `rd_ready` in 1: consumer accepts read completion.
- `rd_tag` out TAG_W: tag of the presented read.
- `rd_data` out DATA_W: data of the presented read.
- `wr_valid` out 1: in-order write completion available.
- `wr_ready` in 1: consumer accepts write completion.
- `wr_tag` out TAG_W: tag of the presented write.
- `rd_pending` out TAG_W+1: occupied read slots, excluding the output register.
- `wr_pending` out TAG_W+1: occupied write slots, excluding the output register.
- `dup_err` out 1: sticky; set when a completion hits an occupied slot or the held output tag.

## Operation
**Storage.** Per type, a slot array of 2^TAG_W entries:
- Read entries hold {occupied, data}.
- Write entries hold {occupied}.

**Head pointers.** One per type, `rd_head` and `wr_head`, each TAG_W bits.
- Advance by one when that type's output register is loaded.
- Wrap modulo 2^TAG_W.

**Output registers.** One per channel, holding {valid, tag, data}.
- Loadable when empty, or when valid && ready this cycle.

**Per channel, each cycle, priority order:**
1. Loadable, `slot[head]` occupied: load the output register from the slot, clear the slot, head++.
2. Loadable, slot empty, and `in_valid` of this type with `in_tag == head`: bypass. Load the output register directly from the input; head++; the slot is not written.
3. Otherwise, a valid input of this type writes `slot[in_tag]` (occupied=1, data).

**Incoming tag equals head but the output register is not loadable.** The input goes to the slot and is released when the output frees.

**Duplicate completions.** An input whose tag slot is already occupied, or whose tag equals the valid output register tag, is dropped. `dup_err` sets and stays set until `rst`.

**Channel independence.** Read and write channels are independent. Backpressure on one never stalls the other.

**No input backpressure.** Tags are allocated upstream, at most 2^TAG_W outstanding per type, so the input cannot overflow.

**Pending counts.** `rd_pending` / `wr_pending`:
- +1 on a slot write.
- −1 on a slot-to-output load.
- Both in the same cycle: net 0.
- Range 0..2^TAG_W.

## Timing
- Reset values:
  - `rd_valid` = `wr_valid` = 0.
  - `rd_tag` = `rd_data` = `wr_tag` = 0.
  - Pending counts = 0; `dup_err` = 0.
  - All occupied bits = 0; both heads = 0.
- `rst` mid-operation discards all stored and presented completions. No output pulse on the cycle after reset.
- Latency, in-order arrival with a free output register: input at cycle N gives valid at N+1 (bypass).
- Latency from a slot: a slot written at N is releasable at N+1, presented at N+2 at the earliest.
- Sustained throughput: 1 completion per channel per cycle when `ready` is held high.
- Handshake rule: while `valid && !ready`, `tag` and `data` are held stable.
- Handshake rule: `valid` never drops without a handshake, except on `rst`.
- Head wrap: after tag 2^TAG_W−1, the next expected tag is 0.

## Structure
- `types_def` holds:
  - `request_t` (read/write), already present.
  - New constant `RET_TAG_W`, the default for `TAG_W`.
  - Packed struct `ret_entry_t` {occupied, data}.
- One natural sub-module, `return_slot_array`: one instance per type, parametrised on data width (0 for writes). It contains:
  - The slot array.
  - The head pointer.
  - The pending counter.
  - The channel output register and its handshake.
- The top level does type demux and dup-error aggregation.

## Test plan
- **Reset.** Hold `rst` 2 cycles during traffic → all outputs 0, pending 0, next read tag 0 accepted via bypass.
- **In-order bypass.** Reads tags 0,1,2 with data 0xA0,0xA1,0xA2 back-to-back, `rd_ready`=1 → `rd_valid` cycles N+1..N+3 with matching tag/data; `rd_pending` stays 0.
- **Out-of-order release.** Reads tags 3,1,2,0 (data 0x3,0x1,0x2,0x0) → nothing until tag 0 arrives; then tags 0,1,2,3 on 4 consecutive cycles; `rd_pending` peaks at 3.
- **Backpressure.** `rd_ready`=0 for 5 cycles with tags 0,1 received → tag 0 held stable, then tags 0,1 on the two cycles after `rd_ready`=1. Writes interleaved on tags 0..3 meanwhile complete unstalled.
- **Wrap.** TAG_W=2; stream write tags 0..3, then 0..3 again, out of order within each window → `wr_tag` sequence 0,1,2,3,0,1,2,3.
- **Duplicate.** Read tag 5 twice while held → second dropped, `dup_err`=1 persists until `rst`, single `rd_valid` for tag 5.

Source files
------------

// File: rtl/types_def.sv
// -----------------------------------------------------------------------------
// types_def
// Shared types for the TXN controller front end.
//   request_t   : completion / request kind (read or write)
//   RET_TAG_W   : default completion tag width for the return reorder buffer
//   RET_DATA_W  : default read data width
//   ret_entry_t : one read slot entry at the default data width
// -----------------------------------------------------------------------------
package types_def;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } request_t;

  localparam int RET_TAG_W  = 6;
  localparam int RET_DATA_W = 32;

  // Layout of one read slot. Write slots carry only the occupied bit.
  typedef struct packed {
    logic                  occupied;
    logic [RET_DATA_W-1:0] data;
  } ret_entry_t;

endpackage

// File: rtl/txn_return_reorder_if.sv
// -----------------------------------------------------------------------------
// txn_return_reorder_if
// Bundle between the back-end response path / front-end requester and the
// return reorder buffer.
//   in_*        : one tagged completion per cycle from the back end
//   rd_*        : in-order read completion channel (valid/ready)
//   wr_*        : in-order write completion channel (valid/ready)
//   *_pending   : slots currently holding a completion (output register excluded)
//   dup_err     : sticky duplicate-completion flag
// Modports: slave = the reorder buffer, master = its environment.
// -----------------------------------------------------------------------------
interface txn_return_reorder_if #(
  parameter int DATA_W = types_def::RET_DATA_W,
  parameter int TAG_W  = types_def::RET_TAG_W
);

  logic                 in_valid;
  types_def::request_t  in_type;
  logic [TAG_W-1:0]     in_tag;
  logic [DATA_W-1:0]    in_data;

  logic                 rd_valid;
  logic                 rd_ready;
  logic [TAG_W-1:0]     rd_tag;
  logic [DATA_W-1:0]    rd_data;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [TAG_W-1:0]     wr_tag;

  logic [TAG_W:0]       rd_pending;
  logic [TAG_W:0]       wr_pending;
  logic                 dup_err;

  modport slave (
    input  in_valid, in_type, in_tag, in_data, rd_ready, wr_ready,
    output rd_valid, rd_tag, rd_data, wr_valid, wr_tag,
    output rd_pending, wr_pending, dup_err
  );

  modport master (
    output in_valid, in_type, in_tag, in_data, rd_ready, wr_ready,
    input  rd_valid, rd_tag, rd_data, wr_valid, wr_tag,
    input  rd_pending, wr_pending, dup_err
  );

endinterface

// File: rtl/return_slot_array.sv
// -----------------------------------------------------------------------------
// return_slot_array
// One completion type's reorder engine: a 2^TAG_W slot array, the head pointer
// (next tag to release), the pending counter and the channel output register
// with its valid/ready handshake. DATA_W = 0 builds a payload-less (write)
// channel; the data ports then shrink to a single unused bit.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : completion of this type present (already type-filtered)
//   in_tag     : completion tag
//   in_data    : completion payload
//   out_valid / out_ready / out_tag / out_data : in-order output channel
//   pending    : occupied slots, output register excluded
//   dup_hit    : this cycle's input was a duplicate and has been dropped
// -----------------------------------------------------------------------------
module return_slot_array import types_def::*; #(
  parameter  int DATA_W = RET_DATA_W,
  parameter  int TAG_W  = RET_TAG_W,
  localparam int DW     = (DATA_W > 0) ? DATA_W : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [DW-1:0]    out_data,
  output logic [TAG_W:0]   pending,
  output logic             dup_hit
);

  localparam int DEPTH = 1 << TAG_W;

  logic [DEPTH-1:0] occ_q, occ_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W:0]   pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [DW-1:0]    out_data_q, out_data_d;

  logic             loadable;
  logic             head_occ;
  logic             dup;
  logic             load_slot;
  logic             bypass;
  logic             slot_wr;
  logic [DW-1:0]    head_data;

  // Payload storage only exists for channels that carry data.
  if (DATA_W > 0) begin : g_data
    logic [DW-1:0] mem_q [DEPTH];

    // NOTE: the payload array has no reset; an entry is only ever read while
    // its occupied bit (which is reset) says it holds a live completion.
    always_ff @(posedge clk) begin
      if (slot_wr) begin
        mem_q[in_tag] <= in_data;
      end
    end

    assign head_data = mem_q[head_q];
  end else begin : g_nodata
    logic unused_in_data;
    assign unused_in_data = ^in_data;
    assign head_data      = '0;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    occ_d       = occ_q;
    head_d      = head_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;

    // The output register can take a new completion when it is empty or is
    // being consumed on this very edge.
    loadable  = !out_valid_q || out_ready;
    head_occ  = occ_q[head_q];

    // A tag already parked in a slot, or still sitting in the output
    // register, cannot legitimately arrive again.
    dup       = in_valid && (occ_q[in_tag] || (out_valid_q && (out_tag_q == in_tag)));

    load_slot = loadable && head_occ;
    bypass    = loadable && !head_occ && in_valid && !dup && (in_tag == head_q);
    slot_wr   = in_valid && !dup && !bypass;

    if (load_slot) begin
      occ_d[head_q] = 1'b0;
    end
    if (slot_wr) begin
      occ_d[in_tag] = 1'b1;
    end

    if (load_slot || bypass) begin
      head_d = head_q + 1'b1;   // wraps modulo 2^TAG_W
    end

    unique case ({slot_wr, load_slot})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase

    if (load_slot) begin
      out_valid_d = 1'b1;
      out_tag_d   = head_q;
      out_data_d  = head_data;
    end else if (bypass) begin
      out_valid_d = 1'b1;
      out_tag_d   = head_q;
      out_data_d  = in_data;
    end else if (out_valid_q && out_ready) begin
      // Tag/data are left as they were; only valid drops after the handshake.
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= '0;
      head_q      <= '0;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else begin
      occ_q       <= occ_d;
      head_q      <= head_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;
  assign pending   = pend_q;
  assign dup_hit   = dup;

endmodule

// File: rtl/txn_return_reorder.sv
// -----------------------------------------------------------------------------
// txn_return_reorder
// In-order completion buffer. Out-of-order read and write completions, tagged
// with their request index, are parked per type and released strictly in tag
// order on independent read and write valid/ready channels.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears all stored/presented state
//   bus  : txn_return_reorder_if.slave (completion input, rd/wr output
//          channels, pending counts, sticky dup_err)
// The top only splits the input by type and aggregates the duplicate flag;
// each channel is a return_slot_array.
// -----------------------------------------------------------------------------
module txn_return_reorder import types_def::*; #(
  parameter int DATA_W = RET_DATA_W,
  parameter int TAG_W  = RET_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  txn_return_reorder_if.slave  bus
);

  logic       rd_in_valid;
  logic       wr_in_valid;
  logic       rd_dup;
  logic       wr_dup;
  logic       dup_err_q, dup_err_d;
  logic [0:0] wr_data_unused;

  always_comb begin
    rd_in_valid = bus.in_valid && (bus.in_type == REQ_READ);
    wr_in_valid = bus.in_valid && (bus.in_type == REQ_WRITE);
    dup_err_d   = dup_err_q || rd_dup || wr_dup;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dup_err_q <= 1'b0;
    end else begin
      dup_err_q <= dup_err_d;
    end
  end

  return_slot_array #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_rd (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_in_valid),
    .in_tag    (bus.in_tag),
    .in_data   (bus.in_data),
    .out_valid (bus.rd_valid),
    .out_ready (bus.rd_ready),
    .out_tag   (bus.rd_tag),
    .out_data  (bus.rd_data),
    .pending   (bus.rd_pending),
    .dup_hit   (rd_dup)
  );

  // Write completions carry no payload.
  return_slot_array #(
    .DATA_W (0),
    .TAG_W  (TAG_W)
  ) u_wr (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (wr_in_valid),
    .in_tag    (bus.in_tag),
    .in_data   (1'b0),
    .out_valid (bus.wr_valid),
    .out_ready (bus.wr_ready),
    .out_tag   (bus.wr_tag),
    .out_data  (wr_data_unused),
    .pending   (bus.wr_pending),
    .dup_hit   (wr_dup)
  );

  assign bus.dup_err = dup_err_q;

endmodule
